// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage types: FSM states, default timeout data, and the
// control bundle handed from MEM to the WB stage.
package mips_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] rd_rt;
    } ctrl_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the retiring instruction's fields, or a
// zero bubble while the MEM stage is stalled.
module mem_wb_reg
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  ctrl_t       i_ctrl,
    input  logic [31:0] i_r,
    input  logic [31:0] i_mdata,
    output ctrl_t       o_ctrl,
    output logic [31:0] o_r,
    output logic [31:0] o_mdata
);

    ctrl_t       r_ctrl;
    logic [31:0] r_r;
    logic [31:0] r_mdata;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_stall) begin
            r_ctrl  <= '0;
            r_r     <= '0;
            r_mdata <= '0;
        end else begin
            r_ctrl  <= i_ctrl;
            r_r     <= i_r;
            r_mdata <= i_mdata;
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_r     = r_r;
    assign o_mdata = r_mdata;

endmodule

// File: rtl/mem_access_ctrl.sv
// MIPS memory-stage access controller: issues loads/stores on a req/ack bus,
// stalls upstream while an access is outstanding, and feeds MEM/WB.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wreg,
    input  logic        m2reg,
    input  logic        wmem,
    input  logic [4:0]  rd_rt,
    input  logic [31:0] r,
    input  logic [31:0] dl,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wreg_out,
    output logic        m2reg_out,
    output logic [4:0]  rd_rt_out,
    output logic [31:0] r_out,
    output logic [31:0] mdata_out,
    output logic        align_err,
    output logic        bus_err
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_align_err;
    logic             r_bus_err;

    logic        w_access;
    logic        w_aligned;
    logic        w_req;
    logic        w_timeout;
    logic        w_load_ack;
    logic        w_misalign;
    logic        w_bus_fail;
    logic        w_stall;
    logic [31:0] w_mdata;
    ctrl_t       w_ctrl_in;
    ctrl_t       w_ctrl_out;

    assign w_access   = wmem | m2reg;
    assign w_aligned  = (r[1:0] == 2'b00);
    // Gating with rst keeps the bus quiet during reset cycles, including mid-WAIT.
    assign w_req      = ~rst & (((r_state == IDLE) & w_access & w_aligned) | (r_state == WAIT));
    assign w_timeout  = (r_state == WAIT) & (r_cnt == CNT_LAST);
    assign w_stall    = w_req & ~mem_ack & ~w_timeout;
    assign w_load_ack = w_req & mem_ack & m2reg & ~wmem;
    assign w_misalign = ~rst & (r_state == IDLE) & w_access & ~w_aligned;
    assign w_bus_fail = ~rst & w_timeout & ~mem_ack;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        w_mdata = '0;
        if (w_load_ack)
            w_mdata = mem_rdata;
        else if (w_bus_fail && m2reg && !wmem)
            w_mdata = ERR_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= w_misalign;
            r_bus_err   <= w_bus_fail;
            case (r_state)
                IDLE: begin
                    if (w_req && !mem_ack) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack || w_timeout)
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_ctrl_in = '{wreg: wreg, m2reg: m2reg, rd_rt: rd_rt};

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .i_stall (w_stall),
        .i_ctrl  (w_ctrl_in),
        .i_r     (r),
        .i_mdata (w_mdata),
        .o_ctrl  (w_ctrl_out),
        .o_r     (r_out),
        .o_mdata (mdata_out)
    );

    assign stall     = w_stall;
    assign mem_req   = w_req;
    assign mem_we    = wmem & w_req;
    assign mem_addr  = r[31:2];
    assign mem_wdata = dl;
    assign wreg_out  = w_ctrl_out.wreg;
    assign m2reg_out = w_ctrl_out.m2reg;
    assign rd_rt_out = w_ctrl_out.rd_rt;
    assign align_err = r_align_err;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected MEM/WB contents are queued as
// each cycle is driven and compared after the following clock edge.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [4:0]  rd_rt;
        logic [31:0] r;
        logic [31:0] mdata;
        logic        align;
        logic        bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wreg, m2reg, wmem;
    logic [4:0]  rd_rt;
    logic [31:0] r, dl, mem_rdata;
    logic        mem_ack;
    logic        stall, mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        wreg_out, m2reg_out;
    logic [4:0]  rd_rt_out;
    logic [31:0] r_out, mdata_out;
    logic        align_err, bus_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .wreg      (wreg),
        .m2reg     (m2reg),
        .wmem      (wmem),
        .rd_rt     (rd_rt),
        .r         (r),
        .dl        (dl),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .wreg_out  (wreg_out),
        .m2reg_out (m2reg_out),
        .rd_rt_out (rd_rt_out),
        .r_out     (r_out),
        .mdata_out (mdata_out),
        .align_err (align_err),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t res(input logic w, input logic m, input logic [4:0] rd,
                                 input logic [31:0] ra, input logic [31:0] md,
                                 input logic al, input logic bu);
        exp_t e;
        e.wreg = w; e.m2reg = m; e.rd_rt = rd; e.r = ra; e.mdata = md;
        e.align = al; e.bus = bu;
        return e;
    endfunction

    task automatic drive(input logic w, input logic m, input logic s, input logic [4:0] rd,
                         input logic [31:0] ra, input logic [31:0] d,
                         input logic ack, input logic [31:0] rdata);
        wreg = w; m2reg = m; wmem = s; rd_rt = rd; r = ra; dl = d;
        mem_ack = ack; mem_rdata = rdata;
        #1;
    endtask

    task automatic comb(input string tag, input logic req, input logic st);
        check({tag, "_req"}, {31'd0, mem_req}, {31'd0, req});
        check({tag, "_stall"}, {31'd0, stall}, {31'd0, st});
    endtask

    // Advance one edge and compare the registered outputs against the queue head.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_wreg"},  {31'd0, wreg_out},  {31'd0, e.wreg});
            check({tag, "_m2reg"}, {31'd0, m2reg_out}, {31'd0, e.m2reg});
            check({tag, "_rd_rt"}, {27'd0, rd_rt_out}, {27'd0, e.rd_rt});
            check({tag, "_r"},     r_out,              e.r);
            check({tag, "_mdata"}, mdata_out,          e.mdata);
            check({tag, "_align"}, {31'd0, align_err}, {31'd0, e.align});
            check({tag, "_bus"},   {31'd0, bus_err},   {31'd0, e.bus});
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        sb_q.push_back('0);
        tick("reset");

        // Access presented during reset: combinational outputs must stay low.
        drive(1, 1, 1, 5'd7, 32'h100, 32'h1, 0, 32'h0);
        comb("rst_comb", 0, 0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        sb_q.push_back('0);
        tick("reset2");

        // Zero-wait load.
        rst = 1'b0;
        drive(1, 1, 0, 5'd8, 32'h100, 32'h0, 1, 32'h1234);
        comb("ld0", 1, 0);
        check("ld0_addr", {2'b00, mem_addr}, 32'h40);
        check("ld0_we", {31'd0, mem_we}, 32'd0);
        sb_q.push_back(res(1, 1, 5'd8, 32'h100, 32'h1234, 0, 0));
        tick("ld0");

        // Store with three wait cycles.
        drive(0, 0, 1, 5'd3, 32'h200, 32'hCAFE, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            comb("st_wait", 1, 1);
            check("st_we", {31'd0, mem_we}, 32'd1);
            check("st_wdata", mem_wdata, 32'hCAFE);
            check("st_addr", {2'b00, mem_addr}, 32'h80);
            sb_q.push_back('0);
            tick("st_bubble");
        end
        drive(0, 0, 1, 5'd3, 32'h200, 32'hCAFE, 1, 32'h9999);
        comb("st_ack", 1, 0);
        sb_q.push_back(res(0, 0, 5'd3, 32'h200, 32'h0, 0, 0));
        tick("st_done");

        // Misaligned load with a stray ack that must be ignored.
        drive(1, 1, 0, 5'd9, 32'h102, 32'h0, 1, 32'h77);
        comb("mis", 0, 0);
        sb_q.push_back(res(1, 1, 5'd9, 32'h102, 32'h0, 1, 0));
        tick("mis");

        // Non-access instruction passes straight through.
        drive(1, 0, 0, 5'd4, 32'h55, 32'h0, 0, 32'h0);
        comb("alu", 0, 0);
        sb_q.push_back(res(1, 0, 5'd4, 32'h55, 32'h0, 0, 0));
        tick("alu");

        // Load that never gets acked: four stall cycles, then timeout.
        drive(1, 1, 0, 5'd10, 32'h300, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            comb("to_wait", 1, 1);
            sb_q.push_back('0);
            tick("to_bubble");
        end
        comb("to_last", 1, 0);
        sb_q.push_back(res(1, 1, 5'd10, 32'h300, 32'hDEADBEEF, 0, 1));
        tick("to_done");
        drive(0, 0, 0, 5'd2, 32'h66, 32'h0, 0, 32'h0);
        comb("to_idle", 0, 0);
        sb_q.push_back(res(0, 0, 5'd2, 32'h66, 32'h0, 0, 0));
        tick("to_after");

        // Back-to-back zero-wait loads.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, 0, 5'(10 + i), 32'h400 + 32'(4 * i), 32'h0, 1, 32'(i));
            comb("b2b", 1, 0);
            sb_q.push_back(res(1, 1, 5'(10 + i), 32'h400 + 32'(4 * i), 32'(i), 0, 0));
            tick("b2b");
        end

        // Reset while waiting; a late ack afterwards must change nothing.
        drive(1, 1, 0, 5'd12, 32'h500, 32'h0, 0, 32'h0);
        comb("rw_req", 1, 1);
        sb_q.push_back('0);
        tick("rw_enter");
        comb("rw_wait", 1, 1);
        rst = 1'b1;
        #1;
        comb("rw_rst", 0, 0);
        sb_q.push_back('0);
        tick("rw_reset");
        rst = 1'b0;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'h5);
        comb("rw_late", 0, 0);
        sb_q.push_back('0);
        tick("rw_late");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
